// File: rtl/axis_pkg.sv
// axis_pkg: shared AXI-Stream parameter record, beat type
// and width helpers used by stream blocks.
package axis_pkg;

    typedef struct packed {
        int TDATA_BYTES;
        int TID_WIDTH;
        int TDEST_WIDTH;
        int TUSER_WIDTH;
    } axis_parameters_t;

    localparam axis_parameters_t AXIS_PARAMETERS_DEFAULT = '{
        TDATA_BYTES: 4,
        TID_WIDTH:   8,
        TDEST_WIDTH: 4,
        TUSER_WIDTH: 2
    };

    localparam int AXIS_TDATA_W = 8 * AXIS_PARAMETERS_DEFAULT.TDATA_BYTES;
    localparam int AXIS_TKEEP_W = AXIS_PARAMETERS_DEFAULT.TDATA_BYTES;
    localparam int AXIS_TID_W   = AXIS_PARAMETERS_DEFAULT.TID_WIDTH;
    localparam int AXIS_TDEST_W = AXIS_PARAMETERS_DEFAULT.TDEST_WIDTH;
    localparam int AXIS_TUSER_W = AXIS_PARAMETERS_DEFAULT.TUSER_WIDTH;

    typedef struct packed {
        logic [AXIS_TDATA_W-1:0] tdata;
        logic [AXIS_TKEEP_W-1:0] tkeep;
        logic                    tlast;
        logic [AXIS_TID_W-1:0]   tid;
        logic [AXIS_TDEST_W-1:0] tdest;
        logic [AXIS_TUSER_W-1:0] tuser;
    } axis_beat_t;

    // Flat width of one beat laid out as {tdata,tkeep,tlast,tid,tdest,tuser}.
    function automatic int axis_beat_width(axis_parameters_t p);
        return 9 * p.TDATA_BYTES + 1 + p.TID_WIDTH
             + p.TDEST_WIDTH + p.TUSER_WIDTH;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry register slice. Input ready comes
// from registered state only; output is a plain register.
module axis_skid_buffer
    import axis_pkg::*;
#(
    parameter axis_parameters_t AXIS_PARAMS = AXIS_PARAMETERS_DEFAULT,
    localparam int W = axis_beat_width(AXIS_PARAMS)
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic         out_vld;
    logic         skid_vld;
    logic [W-1:0] out_q;
    logic [W-1:0] skid_q;

    assign s_ready = ~skid_vld;
    assign m_valid = out_vld;
    assign m_data  = out_q;

    // Refill the output register when it drains; park a beat in the skid slot on a stall.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
        end else if (m_ready || !out_vld) begin
            if (skid_vld) begin
                out_vld  <= 1'b1;
                out_q    <= skid_q;
                skid_vld <= 1'b0;
            end else begin
                out_vld <= s_valid;
                if (s_valid) out_q <= s_data;
            end
        end else if (s_valid && !skid_vld) begin
            skid_vld <= 1'b1;
            skid_q   <= s_data;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin merge of N AXI-Stream
// inputs onto one output through a registered skid stage.
module axis_rr_arbiter
    import axis_pkg::*;
#(
    parameter axis_parameters_t AXIS_PARAMS   = AXIS_PARAMETERS_DEFAULT,
    parameter int               N_INPUTS      = 4,
    parameter int               TID_FROM_PORT = 0,
    localparam int DW = 8 * AXIS_PARAMS.TDATA_BYTES,
    localparam int KW = AXIS_PARAMS.TDATA_BYTES,
    localparam int IW = AXIS_PARAMS.TID_WIDTH,
    localparam int SW = AXIS_PARAMS.TDEST_WIDTH,
    localparam int UW = AXIS_PARAMS.TUSER_WIDTH,
    localparam int GW = $clog2(N_INPUTS)
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [N_INPUTS-1:0]    s_axis_tvalid,
    output logic [N_INPUTS-1:0]    s_axis_tready,
    input  logic [N_INPUTS*DW-1:0] s_axis_tdata,
    input  logic [N_INPUTS*KW-1:0] s_axis_tkeep,
    input  logic [N_INPUTS-1:0]    s_axis_tlast,
    input  logic [N_INPUTS*IW-1:0] s_axis_tid,
    input  logic [N_INPUTS*SW-1:0] s_axis_tdest,
    input  logic [N_INPUTS*UW-1:0] s_axis_tuser,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DW-1:0]          m_axis_tdata,
    output logic [KW-1:0]          m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [IW-1:0]          m_axis_tid,
    output logic [SW-1:0]          m_axis_tdest,
    output logic [UW-1:0]          m_axis_tuser,
    output logic [GW-1:0]          grant_idx,
    output logic                   busy
);

    localparam int BW = axis_beat_width(AXIS_PARAMS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PASS = 1'b1;

    logic [0:0]    state_q;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] start_q;
    logic [GW-1:0] start_nxt;

    logic          sel_valid;
    logic          sel_last;
    logic [DW-1:0] sel_data;
    logic [KW-1:0] sel_keep;
    logic [IW-1:0] sel_id;
    logic [SW-1:0] sel_dest;
    logic [UW-1:0] sel_user;
    logic [BW-1:0] sel_beat;
    logic [BW-1:0] m_beat;
    logic          beat_valid;
    logic          skid_ready;
    logic          beat_acc;

    // First requesting index at or after start, wrapping modulo N_INPUTS.
    function automatic logic [GW-1:0] rr_pick(
        input logic [N_INPUTS-1:0] req,
        input logic [GW-1:0]       start
    );
        logic [GW-1:0] pick;
        logic          found;
        int            idx;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < N_INPUTS; k++) begin
            idx = int'(start) + k;
            if (idx >= N_INPUTS) idx = idx - N_INPUTS;
            if (!found && req[GW'(idx)]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
        return pick;
    endfunction

    assign busy       = (state_q == ST_PASS);
    assign grant_idx  = grant_q;
    assign sel_valid  = s_axis_tvalid[grant_q];
    assign sel_last   = s_axis_tlast[grant_q];
    assign sel_data   = s_axis_tdata[grant_q*DW +: DW];
    assign sel_keep   = s_axis_tkeep[grant_q*KW +: KW];
    assign sel_dest   = s_axis_tdest[grant_q*SW +: SW];
    assign sel_user   = s_axis_tuser[grant_q*UW +: UW];
    assign beat_valid = busy && sel_valid;
    assign beat_acc   = beat_valid && skid_ready;
    assign start_nxt  = (int'(grant_q) == N_INPUTS - 1) ? '0 : grant_q + 1'b1;

    generate
        if (TID_FROM_PORT != 0) begin : g_tid_port
            assign sel_id = IW'(grant_q);
        end else begin : g_tid_pass
            assign sel_id = s_axis_tid[grant_q*IW +: IW];
        end
    endgenerate

    assign sel_beat = {sel_data, sel_keep, sel_last, sel_id, sel_dest, sel_user};
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast,
            m_axis_tid, m_axis_tdest, m_axis_tuser} = m_beat;

    // Only the granted input sees ready, and only while the skid stage has room.
    always_comb begin
        s_axis_tready = '0;
        if (busy) s_axis_tready[grant_q] = skid_ready;
    end

    // Grant on any request in IDLE; hold it until the last beat is taken.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            start_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant_q <= rr_pick(s_axis_tvalid, start_q);
                        state_q <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (beat_acc && sel_last) begin
                        start_q <= start_nxt;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    axis_skid_buffer #(
        .AXIS_PARAMS(AXIS_PARAMS)
    ) u_skid (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (beat_valid),
        .s_ready (skid_ready),
        .s_data  (sel_beat),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready),
        .m_data  (m_beat)
    );

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: packet-order scoreboard for the round-robin
// AXIS arbiter with random payloads and output backpressure.
module tb_axis_rr_arbiter;
    import axis_pkg::*;

    localparam int N   = 4;
    localparam int DB  = AXIS_PARAMETERS_DEFAULT.TDATA_BYTES;
    localparam int DW  = 8 * DB;
    localparam int IW  = AXIS_PARAMETERS_DEFAULT.TID_WIDTH;
    localparam int DSW = AXIS_PARAMETERS_DEFAULT.TDEST_WIDTH;
    localparam int UW  = AXIS_PARAMETERS_DEFAULT.TUSER_WIDTH;
    localparam int GW  = $clog2(N);

    typedef struct {
        logic [DW-1:0]  data;
        logic [DB-1:0]  keep;
        logic           last;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
        int             src;
    } tb_beat_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic [N-1:0] s_tvalid, s_tready, t_s_tready, s_tlast;
    logic [N*DW-1:0] s_tdata;
    logic [N*DB-1:0] s_tkeep;
    logic [N*IW-1:0] s_tid;
    logic [N*DSW-1:0] s_tdest;
    logic [N*UW-1:0] s_tuser;
    logic m_tvalid, m_tready, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [DB-1:0] m_tkeep;
    logic [IW-1:0] m_tid;
    logic [DSW-1:0] m_tdest;
    logic [UW-1:0] m_tuser;
    logic t_valid, t_last;
    logic [DW-1:0] t_data;
    logic [DB-1:0] t_keep;
    logic [IW-1:0] t_tid;
    logic [DSW-1:0] t_dest;
    logic [UW-1:0] t_user;
    logic [GW-1:0] grant_idx, t_grant;
    logic busy, t_busy;

    tb_beat_t srcq [N][$];
    tb_beat_t newq [N][$];
    tb_beat_t expq [$];
    int pause [N];
    logic [N-1:0] acc;
    int tests, fails, mode, mdl_start;
    int idle_run, s_total, m_total;
    bit after_last, prev_stall;
    axis_beat_t prev_beat;

    always #5 aclk = ~aclk;

    axis_rr_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
        .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
        .grant_idx(grant_idx), .busy(busy)
    );

    axis_rr_arbiter #(.TID_FROM_PORT(1)) dut_t (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(t_s_tready),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tvalid(t_valid), .m_axis_tready(m_tready),
        .m_axis_tdata(t_data), .m_axis_tkeep(t_keep),
        .m_axis_tlast(t_last), .m_axis_tid(t_tid),
        .m_axis_tdest(t_dest), .m_axis_tuser(t_user),
        .grant_idx(t_grant), .busy(t_busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_pkt(input int src, input int len,
                            input int base, input int tid);
        tb_beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = (base < 0) ? DW'($urandom) : DW'(base + k);
            b.keep = DB'($urandom);
            b.last = (k == len - 1);
            b.id   = (tid < 0) ? IW'($urandom) : IW'(tid);
            b.dest = DSW'($urandom);
            b.user = UW'($urandom);
            b.src  = src;
            newq[src].push_back(b);
        end
    endtask

    task automatic apply(input bit tick);
        tb_beat_t b;
        for (int i = 0; i < N; i++)
            if (acc[i]) void'(srcq[i].pop_front());
        acc = '0;
        if (tick) begin
            case (mode)
                0: m_tready = 1'b1;
                1: m_tready = ~m_tready;
                default: m_tready = ($urandom_range(0, 3) != 0);
            endcase
            for (int i = 0; i < N; i++)
                if (pause[i] > 0) pause[i]--;
        end
        for (int i = 0; i < N; i++) begin
            if (pause[i] == 0 && srcq[i].size() > 0) begin
                b = srcq[i][0];
                s_tvalid[i] = 1'b1;
                s_tdata[i*DW +: DW] = b.data;
                s_tkeep[i*DB +: DB] = b.keep;
                s_tlast[i] = b.last;
                s_tid[i*IW +: IW] = b.id;
                s_tdest[i*DSW +: DSW] = b.dest;
                s_tuser[i*UW +: UW] = b.user;
            end else begin
                s_tvalid[i] = 1'b0;
            end
        end
    endtask

    // Expected packet order: first pending input at/after the pointer.
    task automatic commit();
        int pos [N];
        int idx;
        bit found;
        bit more;
        for (int i = 0; i < N; i++) pos[i] = 0;
        more = 1'b1;
        while (more) begin
            found = 1'b0;
            idx = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && pos[(mdl_start + k) % N] <
                              newq[(mdl_start + k) % N].size()) begin
                    found = 1'b1;
                    idx = (mdl_start + k) % N;
                end
            end
            more = found;
            if (found) begin
                bit done;
                done = 1'b0;
                while (!done) begin
                    expq.push_back(newq[idx][pos[idx]]);
                    done = newq[idx][pos[idx]].last;
                    pos[idx]++;
                end
                mdl_start = (idx + 1) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            foreach (newq[i][k]) srcq[i].push_back(newq[i][k]);
            newq[i].delete();
        end
        after_last = 1'b0;
        apply(1'b0);
    endtask

    task automatic sample();
        axis_beat_t cur;
        tb_beat_t e;
        cur = {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
        acc = s_tvalid & s_tready;
        s_total += $countones(acc);
        tests++;
        if (!$onehot0(s_tready)) begin
            fails++;
            $display("FAIL ready_onehot got=%b", s_tready);
        end
        if (prev_stall) begin
            tests++;
            if (!m_tvalid || cur !== prev_beat) begin
                fails++;
                $display("FAIL stall_hold got=%h exp=%h", cur, prev_beat);
            end
        end
        prev_stall = m_tvalid && !m_tready;
        prev_beat = cur;
        if (m_tvalid && m_tready) begin
            m_total++;
            if (mode == 0 && after_last) begin
                tests++;
                if (idle_run != 1) begin
                    fails++;
                    $display("FAIL bubble got=%0d exp=1", idle_run);
                end
            end
            after_last = m_tlast;
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat got=%h", cur);
            end else begin
                e = expq.pop_front();
                if (cur !== {e.data, e.keep, e.last, e.id, e.dest, e.user}) begin
                    fails++;
                    $display("FAIL beat src=%0d got=%h exp=%h", e.src, cur,
                             {e.data, e.keep, e.last, e.id, e.dest, e.user});
                end
                tests++;
                if ({t_valid, t_data, t_keep, t_last, t_tid, t_dest, t_user} !==
                    {1'b1, e.data, e.keep, e.last, IW'(e.src), e.dest, e.user}) begin
                    fails++;
                    $display("FAIL tid_port got_tid=%h exp_tid=%h",
                             t_tid, IW'(e.src));
                end
            end
        end
        if (m_tvalid) idle_run = 0;
        else idle_run++;
        tests++;
        if (s_total - m_total > 2 || s_total < m_total) begin
            fails++;
            $display("FAIL inflight got=%0d exp<=2", s_total - m_total);
        end
    endtask

    task automatic step();
        @(negedge aclk);
        sample();
        @(posedge aclk);
        #1;
        apply(1'b1);
    endtask

    task automatic drain(input int budget);
        int n;
        bit pend;
        n = 0;
        pend = 1'b1;
        while (pend && n < budget) begin
            pend = m_tvalid || expq.size() != 0;
            for (int i = 0; i < N; i++)
                if (srcq[i].size() != 0) pend = 1'b1;
            if (pend) begin
                step();
                n++;
            end
        end
        tests++;
        if (pend) begin
            fails++;
            $display("FAIL drain_timeout got=%0d exp=0 pending", expq.size());
        end
    endtask

    task automatic clear_tb();
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            newq[i].delete();
            pause[i] = 0;
        end
        expq.delete();
        acc = '0;
        s_tvalid = '0;
        mdl_start = 0;
        after_last = 1'b0;
        prev_stall = 1'b0;
        idle_run = 0;
        s_total = 0;
        m_total = 0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_tb();
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        apply(1'b0);
    endtask

    task automatic check_idle(input string tag);
        tests++;
        if ({m_tvalid, s_tready, busy, grant_idx} !== '0) begin
            fails++;
            $display("FAIL %s got=%b exp=0", tag,
                     {m_tvalid, s_tready, busy, grant_idx});
        end
        tests++;
        if ({t_valid, t_s_tready, t_busy, t_grant} !== '0) begin
            fails++;
            $display("FAIL %s_tid got=%b exp=0", tag,
                     {t_valid, t_s_tready, t_busy, t_grant});
        end
    endtask

    task automatic test_reset();
        mode = 0;
        m_tready = 1'b1;
        s_tdata = '0; s_tkeep = '0; s_tlast = '0;
        s_tid = '0; s_tdest = '0; s_tuser = '0;
        clear_tb();
        #12;
        check_idle("reset_state");
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check_idle("post_reset");
    endtask

    task automatic test_single();
        mode = 0;
        load_pkt(2, 3, 'hA0, -1);
        commit();
        step();
        tests++;
        if ({grant_idx, busy, s_tready, m_tvalid} !== {2'd2, 1'b1, 4'b0100, 1'b0}) begin
            fails++;
            $display("FAIL single_grant got=%b exp=%b",
                     {grant_idx, busy, s_tready, m_tvalid},
                     {2'd2, 1'b1, 4'b0100, 1'b0});
        end
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if ({m_tvalid, m_tdata} !== {1'b1, DW'('hA0 + k)}) begin
                fails++;
                $display("FAIL single_latency got=%h exp=%h",
                         {m_tvalid, m_tdata}, {1'b1, DW'('hA0 + k)});
            end
        end
        tests++;
        if ({busy, m_tlast} !== 2'b01) begin
            fails++;
            $display("FAIL single_busy_drop got=%b exp=01", {busy, m_tlast});
        end
        drain(50);
    endtask

    task automatic test_rr_order();
        do_reset();
        mode = 0;
        for (int p = 0; p < 2; p++) begin
            load_pkt(0, 2, -1, -1);
            load_pkt(1, 2, -1, -1);
            load_pkt(3, 2, -1, -1);
        end
        commit();
        drain(100);
    endtask

    task automatic test_backpressure();
        mode = 1;
        for (int p = 0; p < 3; p++) begin
            load_pkt($urandom_range(0, N - 1), 4, -1, -1);
            commit();
            drain(100);
        end
    endtask

    task automatic test_stall();
        mode = 0;
        m_tready = 1'b1;
        load_pkt(0, 4, -1, -1);
        commit();
        step();
        step();
        pause[0] = 5;
        load_pkt(1, 2, -1, -1);
        commit();
        for (int j = 0; j < 5; j++) begin
            tests++;
            if ({grant_idx, busy, s_tvalid[0], s_tready[1]} !== {2'd0, 1'b1, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL stall_grant got=%b exp=%b",
                         {grant_idx, busy, s_tvalid[0], s_tready[1]},
                         {2'd0, 1'b1, 1'b0, 1'b0});
            end
            step();
        end
        drain(100);
    endtask

    task automatic test_tid_port();
        mode = 0;
        load_pkt(3, 3, -1, 'h55);
        commit();
        drain(50);
    endtask

    task automatic test_random();
        int any;
        mode = 2;
        for (int r = 0; r < 8; r++) begin
            any = 0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1 || (i == N - 1 && any == 0)) begin
                    any = 1;
                    for (int p = 0; p < int'($urandom_range(1, 2)); p++)
                        load_pkt(i, $urandom_range(1, 4), -1, -1);
                end
            end
            commit();
            drain(400);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        mode = 0;
        load_pkt(1, 1, -1, -1);
        load_pkt(2, 4, -1, -1);
        commit();
        for (int j = 0; j < 4; j++) step();
        #2;
        aresetn = 1'b0;
        clear_tb();
        #1;
        check_idle("async_reset");
        @(posedge aclk);
        #3;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        load_pkt(2, 2, -1, -1);
        load_pkt(0, 2, -1, -1);
        commit();
        step();
        tests++;
        if ({busy, grant_idx} !== {1'b1, 2'd0}) begin
            fails++;
            $display("FAIL restart_idx got=%b exp=100", {busy, grant_idx});
        end
        drain(100);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        s_tvalid = '0;
        test_reset();
        test_single();
        test_rr_order();
        test_backpressure();
        test_stall();
        test_tid_port();
        test_random();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
